// File: rtl/msk_share_fifo_pkg.sv
// Shared masked-gadget definitions: slot select encoding and width helpers
// used by the masked share FIFO and its slot registers.
package msk_share_fifo_pkg;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_NEXT = 2'd1,
      SEL_IN   = 2'd2,
      SEL_ZERO = 2'd3
   } slot_sel_e;

   function automatic int sharing_width(input int count, input int d);
      return count * d;
   endfunction

   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/msk_fifo_slot.sv
// One sharing-wide slot register with a share-wise hold/next/in/zero select.
// Masked mux-register composition: the select is non-sensitive control only.
module msk_fifo_slot
   import msk_share_fifo_pkg::*;
#(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  slot_sel_e      sel_i,
   input  logic [W-1:0]   next_i,
   input  logic [W-1:0]   in_i,
   output logic [W-1:0]   q_o
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Each share bit is selected independently; no bit ever combines with another.
   always_comb begin
      q_d = q_q;
      case (sel_i)
         SEL_HOLD: q_d = q_q;
         SEL_NEXT: q_d = next_i;
         SEL_IN:   q_d = in_i;
         SEL_ZERO: q_d = '0;
         default:  q_d = q_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/msk_share_fifo.sv
// Masked shift-register FIFO: head is always slot 0, vacated slots are zeroed,
// and all selects derive only from level, push, pop and flush.
module msk_share_fifo
   import msk_share_fifo_pkg::*;
#(
   parameter int d     = 2,
   parameter int count = 32,
   parameter int DEPTH = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   flush,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [sharing_width(count, d)-1:0]     in_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [sharing_width(count, d)-1:0]     out_data,
   output logic [level_width(DEPTH)-1:0]          level
);

   localparam int W  = sharing_width(count, d);
   localparam int LW = level_width(DEPTH);

   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic          push;
   logic          pop;

   slot_sel_e     slot_sel  [DEPTH];
   logic [W-1:0]  slot_q    [DEPTH];
   logic [W-1:0]  slot_next [DEPTH];

   assign in_ready  = (level_q < LW'(DEPTH)) & ~flush;
   assign out_valid = (level_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // On push+pop the new word lands one below the current level because of the shift.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         slot_sel[k] = SEL_HOLD;
         if (flush) begin
            slot_sel[k] = SEL_ZERO;
         end else if (pop) begin
            if (push && (level_q == LW'(k + 1))) begin
               slot_sel[k] = SEL_IN;
            end else if (k == DEPTH - 1) begin
               slot_sel[k] = SEL_ZERO;
            end else begin
               slot_sel[k] = SEL_NEXT;
            end
         end else if (push && (level_q == LW'(k))) begin
            slot_sel[k] = SEL_IN;
         end
      end
   end

   always_comb begin
      level_d = level_q;
      if (flush) begin
         level_d = '0;
      end else if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi < DEPTH - 1) begin : g_mid
         assign slot_next[gi] = slot_q[gi + 1];
      end else begin : g_last
         assign slot_next[gi] = '0;
      end

      msk_fifo_slot #(
         .W (W)
      ) u_slot (
         .clk    (clk),
         .rst_n  (rst_n),
         .sel_i  (slot_sel[gi]),
         .next_i (slot_next[gi]),
         .in_i   (in_data),
         .q_o    (slot_q[gi])
      );
   end

   assign out_data = slot_q[0];
   assign level    = level_q;

endmodule

// File: tb/tb_msk_share_fifo.sv
// Randomised and directed bench for msk_share_fifo against a queue-based model.
module tb_msk_share_fifo;

   localparam int D   = 2;
   localparam int C   = 8;
   localparam int DEP = 4;
   localparam int W   = C * D;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [2:0]    level;

   int            n_vec = 0;
   int            n_bad = 0;
   bit            chk_en = 1'b0;
   logic [W-1:0]  mq [$];

   always #5 clk = ~clk;

   msk_share_fifo #(
      .d     (D),
      .count (C),
      .DEPTH (DEP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level)
   );

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: an ordered queue of whole words.
   always @(posedge clk) begin
      if (!rst_n || flush) begin
         mq.delete();
      end else begin
         if (mq.size() != 0 && out_ready) begin
            if (in_valid && mq.size() < DEP) mq.push_back(in_data);
            void'(mq.pop_front());
         end else if (in_valid && mq.size() < DEP) begin
            mq.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("level", W'(level), W'(mq.size()));
         check("out_valid", W'(out_valid), W'(mq.size() != 0));
         check("in_ready", W'(in_ready), W'((mq.size() < DEP) && !flush));
         check("out_data", out_data, (mq.size() != 0) ? mq[0] : '0);
      end
   end

   task automatic step(input logic r, input logic fl, input logic iv,
                       input logic [W-1:0] dat, input logic ordy);
      rst_n     = r;
      flush     = fl;
      in_valid  = iv;
      in_data   = dat;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1;

      // Reset with a word offered
      step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
      chk_en = 1'b1;
      step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
      check("rst_level", W'(level), 16'd0);
      check("rst_out_valid", W'(out_valid), 16'd0);
      check("rst_out_data", out_data, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      check("rst_in_ready", W'(in_ready), 16'd1);
      $display("reset: level=%0d out_valid=%0d in_ready=%0d", level, out_valid, in_ready);

      // Fill with out_ready low, then offer a fifth word
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b0, 1'b1, W'(16'h1111 * i), 1'b0);
         $display("push %h level=%0d", W'(16'h1111 * i), level);
      end
      check("full_level", W'(level), 16'd4);
      check("full_in_ready", W'(in_ready), 16'd0);
      step(1'b1, 1'b0, 1'b1, 16'h5555, 1'b0);
      step(1'b1, 1'b0, 1'b1, 16'h5555, 1'b0);
      check("no_fifth_level", W'(level), 16'd4);
      check("head_1111", out_data, 16'h1111);
      for (int i = 1; i <= 4; i++) begin
         check("drain_order", out_data, W'(16'h1111 * i));
         $display("pop %h level=%0d", out_data, level);
         step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      end
      check("drained_level", W'(level), 16'd0);
      check("drained_data", out_data, 16'h0000);

      // Simultaneous traffic at level 2
      step(1'b1, 1'b0, 1'b1, 16'h0C01, 1'b0);
      step(1'b1, 1'b0, 1'b1, 16'h0C02, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b1, W'(16'hA000 + i), 1'b1);
         $display("push/pop in=%h head=%h level=%0d", W'(16'hA000 + i), out_data, level);
      end
      check("stream_level", W'(level), 16'd2);
      check("stream_head", out_data, 16'hA008);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

      // Full with out_ready high: pop only, then push next cycle
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, W'(16'h4000 + i), 1'b0);
      step(1'b1, 1'b0, 1'b1, 16'h5000, 1'b1);
      check("full_pop_level", W'(level), 16'd3);
      check("full_pop_head", out_data, 16'h4001);
      step(1'b1, 1'b0, 1'b1, 16'h5000, 1'b0);
      check("refill_level", W'(level), 16'd4);
      $display("full pop/refill level=%0d head=%h", level, out_data);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

      // Flush mid-stream with a word offered
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, W'(16'h3000 + i), 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0);
      check("flush_level", W'(level), 16'd0);
      check("flush_out_valid", W'(out_valid), 16'd0);
      step(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0);
      check("post_flush_data", out_data, 16'h1234);
      check("post_flush_valid", W'(out_valid), 16'd1);
      $display("flush: then push 1234 head=%h", out_data);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

      // Random shares, traffic, occasional flush and mid-stream reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 60) != 0), ($urandom_range(0, 25) == 0),
              1'($urandom), W'($urandom), 1'($urandom));
         $display("rnd %0d in_v=%0d in=%h out_v=%0d out=%h level=%0d",
                  i, in_valid, in_data, out_valid, out_data, level);
      end

      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/msk_share_fifo.md
# msk_share_fifo

Masked shift-register FIFO that buffers complete sharings between a producer and the masked datapath muxes that consume them. It decouples producer and consumer with valid/ready handshakes. Each stored bit is kept as its d shares. No share of one bit is ever combined with another share or another bit, so masking security reduces to per-share wiring with non-sensitive control. The head entry is always slot 0, so the output needs no data-dependent read mux.

## Interface
Parameters:
- d, 2: number of shares per bit (masking order + 1).
- count, 32: sharings (bits) per word; word width is count*d.
- DEPTH, 4: number of word slots, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  control; synchronously empties the FIFO.
- in_valid  in  1  control; producer offers in_data.
- in_ready  out  1  control; FIFO accepts a word this cycle.
- in_data  in  count*d  sharing; bit layout passed through unchanged.
- out_valid  out  1  control; out_data holds the head word.
- out_ready  in  1  control; consumer takes the head this cycle.
- out_data  out  count*d  sharing; registered head word (slot 0).
- level  out  $clog2(DEPTH+1)  control; number of valid slots.

Formal-verification annotations:
- Control ports carry fv_type "control".
- in_data and out_data carry fv_type "sharing", fv_count=count.
- in_data latency is 0; out_data latency is 1.

## Operation
- State: slots data[0..DEPTH-1], each count*d bits, plus the valid-slot counter level.
- Valid slots are always contiguous from slot 0.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (level < DEPTH) & ~flush. in_ready depends only on registered state and flush; there is no combinational path from out_ready.
- out_valid = (level != 0). out_data = data[0].
- Slot update, per slot k, next value is one of: hold, data[k+1], in_data, or zero.
  - push only: data[level] <= in_data; level+1.
  - pop only: data[k] <= data[k+1] for k < DEPTH-1; data[DEPTH-1] <= 0; level-1.
  - push & pop: shift as for pop, then data[level-1] <= in_data; level unchanged.
  - neither: all slots hold.
- Vacated slots are zeroed so stale shares never persist in unused registers.
- flush = 1: next cycle level = 0 and all slots are zero. Flush overrides push and pop; any offered word is dropped.
- Reset (rst_n = 0 at a clock edge): level = 0 and all slots zero. Reset has priority over flush and the handshakes; it may be asserted mid-stream.
- Select signals derive only from level, push, pop and flush. Share values never influence control.
- out_data is a direct register output; no logic between the slot register and the port.

## Timing
- Reset values: out_valid = 0, out_data = 0, level = 0, in_ready = 1 after rst_n deasserts (provided flush = 0).
- Latency: a word pushed at edge t is visible on out_data, with out_valid = 1, in the cycle after edge t. There is no empty bypass.
- Throughput: one push and one pop per cycle, sustained at any level.
- Full (level = DEPTH): in_ready = 0 even if out_ready = 1. A pop that cycle makes in_ready = 1 the next cycle.
- Empty (level = 0): out_ready is ignored and no pop occurs.
- level updates one cycle after the handshake edge.

## Structure
- Shared masked-gadgets package holds:
  - the sharing-width helper function: count*d;
  - the level-width helper function: $clog2(DEPTH+1).
- Sub-module msk_fifo_slot: one count*d-bit register with a 4-way share-wise select (hold / next / in / zero).
  - Selects are non-sensitive control; the sub-module is annotated as a masked mux-register composition.
  - The top instantiates DEPTH copies plus the level counter and handshake logic.

## Test plan
All scenarios use d=2, count=8, DEPTH=4.
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> level = 0, out_valid = 0, out_data = 0x0000; in_ready = 1 the cycle after release.
- Fill and drain, out_ready = 0:
  - push 0x1111, 0x2222, 0x3333, 0x4444 -> level = 4, in_ready = 0;
  - fifth word 0x5555 is not accepted;
  - then out_ready = 1 -> words exit in order, one per cycle; level returns to 0; all slots read back 0.
- Simultaneous traffic: at level = 2, push and pop every cycle for 10 cycles (words 0xA000+i) -> level stays 2; output order equals input order.
- Full with out_ready = 1: at level = 4, in_valid = 1 and out_ready = 1 -> one pop, no push that cycle; next cycle push accepted; level ends at 4.
- Flush mid-stream: at level = 3, assert flush together with in_valid = 1 (word 0xBEEF) -> next cycle level = 0, out_valid = 0, 0xBEEF discarded; a subsequent push of 0x1234 appears one cycle later.
- Share integrity: push words with random shares -> out_data matches in_data bit-exactly, share by share; no reduced or recombined value is ever observed.
